// File: rtl/ls_pkg.sv
// Shared constants and FSM encoding for the load/store queue.
// Optional misalignment trap is enabled with LS_MISALIGN_CHECK_EN.
package ls_pkg;

    localparam int OPT_WIDTH   = 7;
    localparam int FUNCT_WIDTH = 3;
    localparam int REG_WIDTH   = 5;

    localparam logic [OPT_WIDTH-1:0] OPCODE_L = 7'b0000011;
    localparam logic [OPT_WIDTH-1:0] OPCODE_S = 7'b0100011;

    localparam logic [FUNCT_WIDTH-1:0] FUNCT_B  = 3'b000;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_H  = 3'b001;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_W  = 3'b010;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_BU = 3'b100;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic is_store(input logic [OPT_WIDTH-1:0] opt);
        return opt == OPCODE_S;
    endfunction

endpackage

// File: rtl/ls_queue_if.sv
// Exe broadcast, writeback and memory-controller signals of ls_queue.
// Carries wb_exc only when LS_MISALIGN_CHECK_EN is defined.
interface ls_queue_if
    import ls_pkg::*;
#(
    parameter int SB_SIZE_WIDTH = 4,
    parameter int DATA_WIDTH    = 32
);

    logic                     valid;
    logic                     dest;
    logic [SB_SIZE_WIDTH-1:0] pos;
    logic [OPT_WIDTH-1:0]     opt;
    logic [FUNCT_WIDTH-1:0]   funct;
    logic [REG_WIDTH-1:0]     rd;
    logic [DATA_WIDTH-1:0]    imm;
    logic [DATA_WIDTH-1:0]    rs1;
    logic [DATA_WIDTH-1:0]    rs2;
    logic                     full;
    logic                     flush;

    logic                     wb_valid;
    logic [SB_SIZE_WIDTH-1:0] wb_pos;
    logic [REG_WIDTH-1:0]     wb_rd;
    logic [DATA_WIDTH-1:0]    wb_value;
`ifdef LS_MISALIGN_CHECK_EN
    logic                     wb_exc;
`endif

    logic                     mc_valid;
    logic                     mc_we;
    logic [DATA_WIDTH-1:0]    mc_addr;
    logic [DATA_WIDTH-1:0]    mc_src;
    logic [3:0]               mc_be;
    logic                     mc_done;
    logic [DATA_WIDTH-1:0]    mc_data;

    modport slave (
        input  valid, dest, pos, opt, funct, rd, imm, rs1, rs2,
        input  flush, mc_done, mc_data,
`ifdef LS_MISALIGN_CHECK_EN
        output wb_exc,
`endif
        output full, wb_valid, wb_pos, wb_rd, wb_value,
        output mc_valid, mc_we, mc_addr, mc_src, mc_be
    );

    modport master (
        output valid, dest, pos, opt, funct, rd, imm, rs1, rs2,
        output flush, mc_done, mc_data,
`ifdef LS_MISALIGN_CHECK_EN
        input  wb_exc,
`endif
        input  full, wb_valid, wb_pos, wb_rd, wb_value,
        input  mc_valid, mc_we, mc_addr, mc_src, mc_be
    );

endinterface

// File: rtl/ls_align.sv
// Byte-lane steering: store data/enables, load extension, misalign flag.
// Purely combinational; unaffected by LS_MISALIGN_CHECK_EN.
module ls_align
    import ls_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [FUNCT_WIDTH-1:0] i_funct,
    input  logic [1:0]             i_lane,
    input  logic [DATA_WIDTH-1:0]  i_rs2,
    input  logic [DATA_WIDTH-1:0]  i_rdata,
    output logic [DATA_WIDTH-1:0]  o_src,
    output logic [3:0]             o_be,
    output logic [DATA_WIDTH-1:0]  o_ld_val,
    output logic                   o_mis
);

    logic [4:0]            w_sh;
    logic [DATA_WIDTH-1:0] w_rd_sh;

    assign w_sh    = {i_lane, 3'b000};
    assign w_rd_sh = i_rdata >> w_sh;
    assign o_src   = i_rs2 << w_sh;

    always_comb begin
        o_ld_val = w_rd_sh;
        unique case (i_funct)
            FUNCT_B:  o_ld_val = {{(DATA_WIDTH-8){w_rd_sh[7]}}, w_rd_sh[7:0]};
            FUNCT_H:  o_ld_val = {{(DATA_WIDTH-16){w_rd_sh[15]}}, w_rd_sh[15:0]};
            FUNCT_BU: o_ld_val = {{(DATA_WIDTH-8){1'b0}}, w_rd_sh[7:0]};
            FUNCT_HU: o_ld_val = {{(DATA_WIDTH-16){1'b0}}, w_rd_sh[15:0]};
            default:  o_ld_val = w_rd_sh;
        endcase
    end

    // funct[1:0] alone carries the access size for both signed and unsigned
    always_comb begin
        o_be  = 4'b1111;
        o_mis = 1'b0;
        unique case (i_funct[1:0])
            2'b00: o_be = 4'b0001 << i_lane;
            2'b01: begin
                o_be  = 4'b0011 << i_lane;
                o_mis = i_lane[0];
            end
            default: o_mis = (i_lane != 2'b00);
        endcase
    end

endmodule

// File: rtl/ls_queue.sv
// In-order load/store queue feeding the memory controller one op at a time.
// LS_MISALIGN_CHECK_EN: misaligned ops trap to wb with wb_exc instead of issuing.
module ls_queue
    import ls_pkg::*;
#(
    parameter int SB_SIZE_WIDTH   = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int LSQ_DEPTH_WIDTH = 2
) (
    input logic       clk,
    input logic       rst_n,
    ls_queue_if.slave bus
);

    localparam int DEPTH = 1 << LSQ_DEPTH_WIDTH;

    typedef logic [LSQ_DEPTH_WIDTH-1:0] ptr_t;
    typedef logic [LSQ_DEPTH_WIDTH:0]   cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    logic [SB_SIZE_WIDTH-1:0] r_q_pos   [DEPTH];
    logic [REG_WIDTH-1:0]     r_q_rd    [DEPTH];
    logic [OPT_WIDTH-1:0]     r_q_opt   [DEPTH];
    logic [FUNCT_WIDTH-1:0]   r_q_funct [DEPTH];
    logic [DATA_WIDTH-1:0]    r_q_addr  [DEPTH];
    logic [DATA_WIDTH-1:0]    r_q_rs2   [DEPTH];

    ptr_t   r_head;
    ptr_t   r_tail;
    cnt_t   r_count;
    logic   r_full;
    state_t r_state;
    logic   r_kill;

    logic [SB_SIZE_WIDTH-1:0] r_if_pos;
    logic [REG_WIDTH-1:0]     r_if_rd;
    logic [FUNCT_WIDTH-1:0]   r_if_funct;
    logic                     r_if_st;

    logic                     r_mc_valid;
    logic                     r_mc_we;
    logic [DATA_WIDTH-1:0]    r_mc_addr;
    logic [DATA_WIDTH-1:0]    r_mc_src;
    logic [3:0]               r_mc_be;

    logic                     r_wb_valid;
    logic [SB_SIZE_WIDTH-1:0] r_wb_pos;
    logic [REG_WIDTH-1:0]     r_wb_rd;
    logic [DATA_WIDTH-1:0]    r_wb_value;
`ifdef LS_MISALIGN_CHECK_EN
    logic                     r_wb_exc;
`endif

    logic                     w_push;
    logic                     w_pop;
    logic                     w_done;
    logic                     w_issue_ok;
    logic                     w_issue;
    logic                     w_mis_pop;
    logic [DATA_WIDTH-1:0]    w_addr;
    cnt_t                     w_count_nxt;

    logic [SB_SIZE_WIDTH-1:0] w_h_pos;
    logic [REG_WIDTH-1:0]     w_h_rd;
    logic                     w_h_st;
    logic [FUNCT_WIDTH-1:0]   w_h_funct;
    logic [DATA_WIDTH-1:0]    w_h_addr;

    logic [FUNCT_WIDTH-1:0]   w_al_funct;
    logic [1:0]               w_al_lane;
    logic [DATA_WIDTH-1:0]    w_src;
    logic [3:0]               w_be;
    logic [DATA_WIDTH-1:0]    w_ld_val;
    logic                     w_mis;

    assign w_h_pos   = r_q_pos[r_head];
    assign w_h_rd    = r_q_rd[r_head];
    assign w_h_st    = is_store(r_q_opt[r_head]);
    assign w_h_funct = r_q_funct[r_head];
    assign w_h_addr  = r_q_addr[r_head];

    assign w_addr = bus.rs1 + bus.imm;
    assign w_push = bus.valid && bus.dest && !r_full && !bus.flush;
    assign w_done = (r_state == BUSY) && bus.mc_done;

    assign w_issue_ok = (r_state == IDLE) && (r_count != '0) && !bus.flush;

`ifdef LS_MISALIGN_CHECK_EN
    // Holding off while wb_valid is high keeps result pulses non-adjacent
    assign w_mis_pop = w_issue_ok && w_mis && !r_wb_valid;
    assign w_issue   = w_issue_ok && !w_mis;
`else
    logic w_unused_mis;
    assign w_unused_mis = w_mis;
    assign w_mis_pop    = 1'b0;
    assign w_issue      = w_issue_ok;
`endif

    // A killed in-flight op was already dropped from the queue by the flush
    assign w_pop = (w_done && !r_kill && !bus.flush) || w_mis_pop;

    // Issue uses the head entry; completion uses the in-flight op
    assign w_al_funct = (r_state == BUSY) ? r_if_funct : w_h_funct;
    assign w_al_lane  = (r_state == BUSY) ? r_mc_addr[1:0] : w_h_addr[1:0];

    ls_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_align (
        .i_funct (w_al_funct),
        .i_lane  (w_al_lane),
        .i_rs2   (r_q_rs2[r_head]),
        .i_rdata (bus.mc_data),
        .o_src   (w_src),
        .o_be    (w_be),
        .o_ld_val(w_ld_val),
        .o_mis   (w_mis)
    );

    always_comb begin
        w_count_nxt = r_count;
        if (bus.flush) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + cnt_t'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pos[r_tail]   <= bus.pos;
            r_q_rd[r_tail]    <= bus.rd;
            r_q_opt[r_tail]   <= bus.opt;
            r_q_funct[r_tail] <= bus.funct;
            r_q_addr[r_tail]  <= w_addr;
            r_q_rs2[r_tail]   <= bus.rs2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == DEPTH_C);
            if (bus.flush) begin
                r_head <= r_tail;
            end else begin
                if (w_pop) r_head <= r_head + ptr_t'(1);
                if (w_push) r_tail <= r_tail + ptr_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_kill     <= 1'b0;
            r_if_pos   <= '0;
            r_if_rd    <= '0;
            r_if_funct <= '0;
            r_if_st    <= 1'b0;
            r_mc_valid <= 1'b0;
            r_mc_we    <= 1'b0;
            r_mc_addr  <= '0;
            r_mc_src   <= '0;
            r_mc_be    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_pos   <= '0;
            r_wb_rd    <= '0;
            r_wb_value <= '0;
`ifdef LS_MISALIGN_CHECK_EN
            r_wb_exc   <= 1'b0;
`endif
        end else begin
            r_wb_valid <= 1'b0;
`ifdef LS_MISALIGN_CHECK_EN
            r_wb_exc   <= 1'b0;
`endif
            unique case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_mc_valid <= 1'b1;
                        r_mc_we    <= w_h_st;
                        r_mc_addr  <= w_h_addr;
                        r_mc_src   <= w_h_st ? w_src : '0;
                        r_mc_be    <= w_h_st ? w_be : 4'b0000;
                        r_if_pos   <= w_h_pos;
                        r_if_rd    <= w_h_rd;
                        r_if_funct <= w_h_funct;
                        r_if_st    <= w_h_st;
                        r_kill     <= 1'b0;
                        r_state    <= BUSY;
                    end
`ifdef LS_MISALIGN_CHECK_EN
                    else if (w_mis_pop) begin
                        r_wb_valid <= 1'b1;
                        r_wb_exc   <= 1'b1;
                        r_wb_pos   <= w_h_pos;
                        r_wb_rd    <= w_h_rd;
                        r_wb_value <= w_h_addr;
                    end
`endif
                end
                BUSY: begin
                    if (bus.flush) r_kill <= 1'b1;
                    if (bus.mc_done) begin
                        r_mc_valid <= 1'b0;
                        r_kill     <= 1'b0;
                        r_state    <= IDLE;
                        if (!r_kill && !bus.flush) begin
                            r_wb_valid <= 1'b1;
                            r_wb_pos   <= r_if_pos;
                            r_wb_rd    <= r_if_st ? '0 : r_if_rd;
                            r_wb_value <= r_if_st ? '0 : w_ld_val;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.full     = r_full;
    assign bus.mc_valid = r_mc_valid;
    assign bus.mc_we    = r_mc_we;
    assign bus.mc_addr  = r_mc_addr;
    assign bus.mc_src   = r_mc_src;
    assign bus.mc_be    = r_mc_be;
    assign bus.wb_valid = r_wb_valid;
    assign bus.wb_pos   = r_wb_pos;
    assign bus.wb_rd    = r_wb_rd;
    assign bus.wb_value = r_wb_value;
`ifdef LS_MISALIGN_CHECK_EN
    assign bus.wb_exc   = r_wb_exc;
`endif

endmodule

// File: doc/ls_queue.md
Name: ls_queue

Overview:
- Parametrised successor to the single-entry load/store unit.
- Buffers up to LSQ_DEPTH load/store ops from the exe broadcast and issues them in order to the memory controller.
- Supports byte/half/word accesses with sign/zero extension and store byte enables; returns results to wb_buffer.
- Has a full back-pressure signal and a flush.

Parameters:
- SB_SIZE_WIDTH, 4, width of the scoreboard position tag.
- DATA_WIDTH, 32, data/address width; byte-lane logic is fixed to 4 lanes, so only 32 is legal.
- LSQ_DEPTH_WIDTH, 2, log2 of queue depth; depth = 2**LSQ_DEPTH_WIDTH = 4.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- valid  in  1  exe broadcast valid.
- dest  in  1  0 = alu, 1 = ls; an entry is pushed only when valid && dest && !full.
- pos  in  SB_SIZE_WIDTH  scoreboard position.
- opt  in  7  opcode: 0000011 = load, 0100011 = store.
- funct  in  3  000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- rd  in  5  destination register.
- imm  in  DATA_WIDTH  offset.
- rs1  in  DATA_WIDTH  base operand, captured at push.
- rs2  in  DATA_WIDTH  store data, captured at push.
- full  out  1  registered; count == depth.
- flush  in  1  discard all queued ops.
- wb_valid  out  1  one-cycle result pulse.
- wb_pos  out  SB_SIZE_WIDTH  scoreboard position of the result.
- wb_rd  out  5  destination register of the result.
- wb_value  out  DATA_WIDTH  result value.
- mc_valid  out  1  request; held until mc_done.
- mc_we  out  1  1 = store.
- mc_addr  out  DATA_WIDTH  byte address.
- mc_src  out  DATA_WIDTH  store word, lane-aligned.
- mc_be  out  4  byte enables.
- mc_done  in  1  request complete; sampled only while mc_valid = 1.
- mc_data  in  DATA_WIDTH  aligned read word, valid with mc_done.

Behaviour:
- Reset:
  - On rst_n low, asynchronously clear all outputs to 0, head/tail/count to 0, and state to IDLE.
  - Reset mid-transaction abandons it; no wb_valid is produced.
- Queue:
  - Circular buffer of {pos, rd, opt, funct, addr = rs1 + imm (mod 2^DATA_WIDTH), rs2}.
  - The address is computed at push.
  - Push while full is ignored; the producer must stall on full.
  - Push and pop in the same cycle are both performed and count is unchanged.
  - Pointers wrap modulo depth.
- States:
  - IDLE: if count != 0 and !flush, load the mc_* outputs from the head entry, set mc_valid = 1, go to BUSY. Else mc_valid = 0.
  - BUSY: hold all mc_* outputs stable. On mc_done = 1:
    - set mc_valid <= 0;
    - pop the head;
    - pulse wb_valid = 1 next cycle with wb_pos/wb_rd of that entry;
    - go to IDLE.
- Next issue:
  - Back-to-back issue is not allowed; IDLE always spends one cycle.
  - Minimum push-to-wb latency is 3 cycles when mc_done arrives the first cycle after mc_valid rises.
- Loads:
  - lane = addr[1:0]; shifted = mc_data >> (8*lane).
  - B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
  - mc_be = 0 for loads.
- Stores:
  - mc_src = rs2 << (8*lane).
  - mc_be: B = 0001 << lane, H = 0011 << lane, W = 1111.
  - wb_valid is still pulsed, with wb_rd = 0 and wb_value = 0 (commit notification).
- Misaligned accesses (H with addr[0] = 1, W with addr[1:0] != 0) without the optional feature: issued unchanged; result undefined.
- Flush:
  - All non-issued entries are dropped in the same cycle; count = 0, head = tail. Any same-cycle push is also dropped.
  - If BUSY, the in-flight request is held until mc_done, then completes with wb_valid suppressed.
- wb_valid is never asserted for two consecutive cycles.

Optional Feature:
- Macro: LS_MISALIGN_CHECK_EN.
- Defined: adds output wb_exc (1 bit).
  - A misaligned head entry is not issued to mc.
  - From IDLE it pops directly; next cycle wb_valid = 1, wb_exc = 1, wb_value = addr.
  - wb_exc = 0 for all other results and after reset.
- Undefined: no wb_exc port; misaligned ops are issued as described above.

Decomposition:
- Shared package (ls_pkg):
  - OPT_WIDTH = 7, FUNCT_WIDTH = 3, REG_WIDTH = 5;
  - OPCODE_L, OPCODE_S;
  - FUNCT_B/H/W/BU/HU;
  - state encoding IDLE = 0, BUSY = 1.
- One sub-module: ls_align, purely combinational. Given (funct, addr[1:0], rs2, mc_data) it produces (mc_src, mc_be, load value, misaligned flag).
- Queue storage and FSM stay in ls_queue.

Test Plan:
- LW at rs1 = 0x100, imm = 4, mc_done after 2 cycles, mc_data = 0xDEADBEEF -> mc_addr = 0x104, mc_be = 0, wb_value = 0xDEADBEEF, wb_pos/rd match.
- LB at addr 0x103 with mc_data = 0x80FF_0000 -> wb_value = 0xFFFFFF80. LBU at the same address -> 0x00000080. LH at 0x102 -> 0xFFFF80FF.
- SB at addr 0x101 with rs2 = 0x1234_56AB -> mc_we = 1, mc_src = 0x3456_AB00, mc_be = 0010. SH at 0x102 -> mc_be = 1100. Store wb_rd = 0.
- Push 5 ops with mc_done held low -> full rises after the 4th push, the 5th push is dropped. Releasing mc_done yields exactly 4 wb pulses in push order, with pointer wrap exercised.
- Flush while BUSY with 3 queued -> in-flight completes on mc_done with no wb_valid, queue empty, full = 0. Assert rst_n low mid-BUSY -> mc_valid = 0 immediately.
- LW at 0x102 with LS_MISALIGN_CHECK_EN -> no mc_valid, wb_exc = 1, wb_value = 0x102.
